// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter that shares one sram-like bus port between instruction fetch
// and the MEM stage, sequencing the addr_ok/data_ok handshake one transaction at a time.
module sram_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_req,
    input  logic [AW-1:0]   inst_addr,
    output logic [DW-1:0]   inst_rdata,
    output logic            inst_ready,
    input  logic            data_req,
    input  logic [DW/8-1:0] data_wen,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic [DW-1:0]   data_rdata,
    output logic            data_ready,
    output logic            bus_req,
    output logic [DW/8-1:0] bus_wstrb,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_addr_ok,
    input  logic            bus_data_ok,
    input  logic [DW-1:0]   bus_rdata,
    output logic            stallreq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   gnt_r;          // 0 = INST, 1 = DATA
    logic   last_grant_r;
    logic   win_data_s;
    logic   start_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and winner selection; a tie goes to the side not served last.
    always_comb begin
        state_nxt_s = state_r;
        win_data_s  = 1'b0;
        start_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (inst_req || data_req) begin
                    state_nxt_s = S_ADDR;
                    start_s     = 1'b1;
                    if (inst_req && data_req) begin
                        win_data_s = ~last_grant_r;
                    end else begin
                        win_data_s = data_req;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ADDR: begin
                if (bus_addr_ok) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_ADDR;
                end
            end
            S_WAIT: begin
                if (bus_data_ok) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Bus command registers, grant bookkeeping, read-data capture and ready pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_r        <= 1'b0;
            last_grant_r <= 1'b0;
            bus_req      <= 1'b0;
            bus_addr     <= {AW{1'b0}};
            bus_wstrb    <= {(DW/8){1'b0}};
            bus_wdata    <= {DW{1'b0}};
            inst_rdata   <= {DW{1'b0}};
            data_rdata   <= {DW{1'b0}};
            inst_ready   <= 1'b0;
            data_ready   <= 1'b0;
        end else begin
            inst_ready <= 1'b0;
            data_ready <= 1'b0;
            if (start_s) begin
                gnt_r        <= win_data_s;
                last_grant_r <= win_data_s;
                bus_req      <= 1'b1;
                bus_addr     <= win_data_s ? data_addr : inst_addr;
                bus_wstrb    <= win_data_s ? data_wen : {(DW/8){1'b0}};
                bus_wdata    <= win_data_s ? data_wdata : {DW{1'b0}};
            end else if (state_r == S_ADDR && bus_addr_ok) begin
                bus_req <= 1'b0;
            end
            // data_ok is only meaningful while waiting; elsewhere it is dropped.
            if (state_r == S_WAIT && bus_data_ok) begin
                if (gnt_r) begin
                    data_rdata <= bus_rdata;
                    data_ready <= 1'b1;
                end else begin
                    inst_rdata <= bus_rdata;
                    inst_ready <= 1'b1;
                end
            end
        end
    end

    assign stallreq = (inst_req & ~inst_ready) | (data_req & ~data_ready);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: vector table of single transactions,
// a bus responder model, and a scoreboard of expected completions.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        bus_req;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        stallreq;

    sram_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_ready(data_ready),
        .bus_req(bus_req), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    typedef struct { logic side; logic [31:0] rdata; logic wr; } exp_t;
    typedef struct { logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata; } bexp_t;
    typedef struct {
        logic is_data; logic [31:0] addr; logic [3:0] wen; logic [31:0] wdata;
        logic [31:0] rdata; int aw; int dw;
    } vec_t;

    exp_t        exp_q[$];
    bexp_t       bexp_q[$];
    logic [31:0] rdata_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          bm, bm_cnt, addr_wait, data_wait;
    bit          bm_en;
    bexp_t       cur_b;
    vec_t        vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pop one expected completion per ready pulse.
    task automatic monitor();
        exp_t e;
        if (inst_ready || data_ready) begin
            chk("ready_onehot", 32'(inst_ready & data_ready), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", {30'd0, inst_ready, data_ready}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ready_side", 32'(data_ready), 32'(e.side));
                if (!e.wr) chk("rdata", e.side ? data_rdata : inst_rdata, e.rdata);
            end
        end
    endtask

    // Bus slave: withholds addr_ok for addr_wait cycles, data_ok for data_wait cycles.
    task automatic bus_model();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        if (bm_en) begin
            if (bm == 0 && bus_req) begin
                if (bexp_q.size() == 0) begin
                    chk("unexpected_bus_req", 32'(bus_req), 32'd0);
                end else begin
                    cur_b = bexp_q.pop_front();
                    bm = 1;
                    bm_cnt = 0;
                end
            end
            if (bm == 1) begin
                chk("bus_req_addr", 32'(bus_req), 32'd1);
                chk("bus_addr", bus_addr, cur_b.addr);
                chk("bus_wstrb", 32'(bus_wstrb), 32'(cur_b.wstrb));
                if (cur_b.wstrb != 4'd0) chk("bus_wdata", bus_wdata, cur_b.wdata);
                if (bm_cnt >= addr_wait) begin
                    bus_addr_ok = 1'b1;
                    bm = 2;
                    bm_cnt = 0;
                end else begin
                    bm_cnt++;
                end
            end else if (bm == 2) begin
                chk("bus_req_wait", 32'(bus_req), 32'd0);
                if (bm_cnt >= data_wait) begin
                    bus_data_ok = 1'b1;
                    bus_rdata = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'h0;
                    bm = 0;
                end else begin
                    bm_cnt++;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        monitor();
        bus_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; inst_req = 1'b0; data_req = 1'b0; bm_en = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        inst_addr = 32'h0; data_addr = 32'h0; data_wen = 4'h0; data_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_ready", {30'd0, inst_ready, data_ready}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        chk("rst_rdata", inst_rdata | data_rdata, 32'h0);
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        rst = 1'b0;
        exp_q.delete(); bexp_q.delete(); rdata_q.delete();
        bm = 0; bm_cnt = 0; bm_en = 1'b1;
    endtask

    initial begin
        int n;
        bit got;
        vec_t v;
        logic [31:0] ia, da;

        vecs[0] = '{1'b0, 32'hbfc00000, 4'h0, 32'h0,        32'h24080001, 0, 0};
        vecs[1] = '{1'b1, 32'h80000000, 4'h0, 32'h0,        32'h11223344, 1, 2};
        vecs[2] = '{1'b1, 32'h80000010, 4'h3, 32'hdeadbeef, 32'h0,        0, 0};
        vecs[3] = '{1'b0, 32'h00000004, 4'h0, 32'h0,        32'ha5a5a5a5, 3, 1};
        vecs[4] = '{1'b1, 32'h80000020, 4'hf, 32'hcafef00d, 32'h0,        2, 0};
        vecs[5] = '{1'b1, 32'hfffffffc, 4'h0, 32'h0,        32'hffffffff, 0, 3};

        do_reset();

        // Table of single-requester transactions.
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            addr_wait = v.aw;
            data_wait = v.dw;
            if (v.is_data) begin
                data_req = 1'b1; data_addr = v.addr; data_wen = v.wen; data_wdata = v.wdata;
                bexp_q.push_back('{v.addr, v.wen, v.wdata});
            end else begin
                inst_req = 1'b1; inst_addr = v.addr;
                bexp_q.push_back('{v.addr, 4'h0, 32'h0});
            end
            exp_q.push_back('{v.is_data, v.rdata, v.wen != 4'h0});
            rdata_q.push_back(v.rdata);
            #1;
            chk("stallreq_req", 32'(stallreq), 32'd1);
            n = 0;
            got = 1'b0;
            while (!got && n < 40) begin
                cycle();
                n++;
                if (inst_ready || data_ready) got = 1'b1;
                else chk("stallreq_busy", 32'(stallreq), 32'd1);
            end
            chk("latency", 32'(n), 32'(3 + v.aw + v.dw));
            chk("stallreq_done", 32'(stallreq), 32'd0);
            inst_req = 1'b0;
            data_req = 1'b0;
            cycle();
        end
        chk("inst_rdata_hold", inst_rdata, 32'ha5a5a5a5);
        chk("data_rdata_hold", data_rdata, 32'hffffffff);
        chk("sb_drained", 32'(exp_q.size() + bexp_q.size()), 32'd0);

        // Both requesting continuously after reset: D, I, D, I.
        do_reset();
        addr_wait = 0; data_wait = 0;
        ia = 32'h00001000; da = 32'h80002000;
        inst_req = 1'b1; inst_addr = ia;
        data_req = 1'b1; data_addr = da; data_wen = 4'h0;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{(k % 2) == 0, 32'h10000000 + 32'(k), 1'b0});
            bexp_q.push_back('{((k % 2) == 0) ? da : ia, 4'h0, 32'h0});
            rdata_q.push_back(32'h10000000 + 32'(k));
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            cycle();
            n++;
            if ((inst_ready || data_ready) && exp_q.size() == 0) got = 1'b1;
        end
        chk("alt_total_cycles", 32'(n), 32'd15);
        inst_req = 1'b0;
        data_req = 1'b0;
        repeat (3) cycle();
        chk("alt_drained", 32'(exp_q.size() + bexp_q.size()), 32'd0);

        // Reset while waiting for data; a late data_ok must be ignored.
        do_reset();
        addr_wait = 0; data_wait = 10;
        data_req = 1'b1; data_addr = 32'h80000040; data_wen = 4'h0;
        bexp_q.push_back('{32'h80000040, 4'h0, 32'h0});
        rdata_q.push_back(32'h77777777);
        n = 0;
        while (bm != 2 && n < 10) begin
            cycle();
            n++;
        end
        chk("reach_wait", 32'(bm), 32'd2);
        cycle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wait_bus_req", 32'(bus_req), 32'd0);
        chk("rst_wait_ready", {30'd0, inst_ready, data_ready}, 32'd0);
        rst = 1'b0;
        data_req = 1'b0;
        bm_en = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata = 32'h55aa55aa;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stray_ready", {30'd0, inst_ready, data_ready}, 32'd0);
            chk("stray_bus_req", 32'(bus_req), 32'd0);
        end
        chk("stray_rdata", data_rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
